button_conditioner: RTL
=======================

# button_conditioner

Input conditioning stage placed directly upstream of the predictive button press counter. Takes raw, asynchronous board switch/button signals (three voting buttons, three equalizer buttons, one activator switch) and synchronises and debounces each one. Produces a single-cycle press pulse per button and a clean level for the activator, so the counter sees exactly one increment/equalize request per physical press.

## Interface
- DEBOUNCE_TICKS, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range 1 .. 2^CNT_WIDTH−1. Simulation benches use 4.
- CNT_WIDTH, 20: width of each per-channel debounce counter.
- RAW_ACTIVE_LOW, 0: 1 = raw inputs are active-low and are inverted before synchronisation. 0 = raw inputs are active-high.
- rst  input  1  asynchronous, active-low reset
- clk  input  1  system clock, rising edge
- activator_raw  input  1  raw activator switch
- buttons_raw  input  3  raw voting buttons
- equalizer_raw  input  3  raw equalizer buttons
- activator  output  1  debounced activator level
- buttons  output  3  one-cycle pulse per accepted press of buttons_raw[i]
- equalizer  output  3  one-cycle pulse per accepted press of equalizer_raw[i]

## Operation
- There are 7 independent, identical channels. Channel order: buttons[0..2], equalizer[0..2], activator.
- Each channel has the following pipeline:
  - Polarity fix: inversion when RAW_ACTIVE_LOW = 1; pass-through otherwise.
  - Synchroniser: two flops, sync1 then sync2.
  - Debounce: a stable level register plus a CNT_WIDTH-bit counter.
  - Pulse register.
- Debounce rule, evaluated at each rising edge:
  - If sync2 == stable, the counter is cleared to 0.
  - If sync2 != stable and counter < DEBOUNCE_TICKS−1, the counter increments by 1.
  - If sync2 != stable and counter == DEBOUNCE_TICKS−1, stable takes the value of sync2 and the counter is cleared.
- Pulse rule:
  - The pulse register is set to 1 exactly on the edge where stable flips 0→1. It is 0 on every other edge.
  - A release (flip 1→0) produces no pulse.
- Output mapping:
  - buttons and equalizer outputs are the pulse registers.
  - activator is the stable register of the activator channel. The activator has no pulse output.
- Bounce rejection: any mismatch run shorter than DEBOUNCE_TICKS cycles clears the counter when the input returns. stable does not change and no pulse is produced.
- Channels never interact:
  - Simultaneous presses on several channels give pulses in the same cycle.
  - A held button gives exactly one pulse, regardless of hold duration.
- The counter never exceeds DEBOUNCE_TICKS−1 and never wraps.

## Timing
- Reset is asynchronous, active-low. While rst = 0, all state clears immediately: sync1, sync2, stable, counters, pulses = 0.
  - Reset values: activator = 0, buttons = 3'b000, equalizer = 3'b000.
  - A logically active raw input during reset is held at 0 until after release.
- Press latency: raw input becomes logically active and is sampled at edge E. Then:
  - sync2 = 1 after edge E+1.
  - stable and the pulse go to 1 after edge E+1+DEBOUNCE_TICKS.
  - The pulse returns to 0 after edge E+2+DEBOUNCE_TICKS.
  - Pulse width is exactly 1 cycle.
- Release latency is identical: stable goes to 0 after edge E+1+DEBOUNCE_TICKS, with no pulse.
- Reset mid-count: the counter is lost. After release, an input still held active is treated as a new press and pulses after full latency measured from the first post-reset sample.
- Reset asserted in the same cycle as a pulse: the pulse is cut short immediately.
- Re-press: a new pulse requires stable to have returned to 0 first. The minimum press-to-press spacing is therefore 2·DEBOUNCE_TICKS cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_TICKS = 4.
- Reset: rst = 0 with all raw inputs = 1 → all outputs 0 throughout reset. After release, held buttons_raw[0] = 1 → buttons[0] pulses once, 5 edges after the first sampling edge. activator rises on the same edge.
- Clean press: buttons_raw[1] goes 0→1 and is held for 20 cycles → buttons = 3'b010 for exactly one cycle, 5 cycles after the first sample; no further pulse while held. Releasing it produces no pulse.
- Bounce: equalizer_raw[2] toggles 1,0,1,0 (one cycle each), then holds 1 → no pulse during the toggling. Exactly one pulse arrives 5 cycles after the final rising sample.
- Simultaneous: buttons_raw = 3'b111 and equalizer_raw[0] = 1 on the same edge → buttons = 3'b111 and equalizer = 3'b001 pulse in the same cycle.
- Glitch reject: activator_raw high for 3 cycles, then low → activator stays 0. Holding it high for 4 or more cycles → activator = 1. A low glitch of 3 cycles leaves it at 1.
- Polarity: RAW_ACTIVE_LOW = 1 with raw idle = 1 → no pulses. Driving buttons_raw[2] = 0 and holding it → buttons[2] pulses once after 5 cycles.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises and debounces seven raw board inputs. There are three voting
//   buttons, three equalizer buttons and one activator switch. The buttons and
//   equalizers each produce a single-cycle pulse per accepted press. The
//   activator produces a clean debounced level.
//
//   Channel order (bit index): 0..2 buttons, 3..5 equalizer, 6 activator.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   activator_raw : raw activator switch
//   buttons_raw   : raw voting buttons [2:0]
//   equalizer_raw : raw equalizer buttons [2:0]
//   activator     : debounced activator level (registered)
//   buttons       : one-cycle press pulse per voting button (registered)
//   equalizer     : one-cycle press pulse per equalizer button (registered)
module button_conditioner #(
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int CNT_WIDTH      = 20,
  parameter bit RAW_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activator_raw,
  input  logic [2:0] buttons_raw,
  input  logic [2:0] equalizer_raw,
  output logic       activator,
  output logic [2:0] buttons,
  output logic [2:0] equalizer
);

  localparam int NCH = 7;
  localparam int NPULSE = 6;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  logic [NCH-1:0]    raw_s;
  logic [NCH-1:0]    sync1_r;
  logic [NCH-1:0]    sync2_r;
  logic [NCH-1:0]    stable_r;
  logic [NCH-1:0]    stable_nxt_s;
  logic [NPULSE-1:0] pulse_r;
  logic [NPULSE-1:0] pulse_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r     [NCH];
  logic [CNT_WIDTH-1:0] cnt_nxt_s [NCH];

  // Polarity fix: normalise every channel so that 1 means "pressed/on".
  always_comb begin
    if (RAW_ACTIVE_LOW) begin
      raw_s = ~{activator_raw, equalizer_raw, buttons_raw};
    end else begin
      raw_s = {activator_raw, equalizer_raw, buttons_raw};
    end
  end

  // Two-flop synchroniser per channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {NCH{1'b0}};
      sync2_r <= {NCH{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state logic. A mismatch must persist for DEBOUNCE_TICKS
  // consecutive edges before stable follows. Any return to agreement clears
  // the run, so the counter never passes CNT_LAST.
  always_comb begin
    stable_nxt_s = stable_r;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_nxt_s[ch] = CNT_ZERO;
      if (sync2_r[ch] == stable_r[ch]) begin
        cnt_nxt_s[ch] = CNT_ZERO;
      end else if (cnt_r[ch] < CNT_LAST) begin
        cnt_nxt_s[ch] = cnt_r[ch] + CNT_ONE;
      end else begin
        stable_nxt_s[ch] = sync2_r[ch];
        cnt_nxt_s[ch]    = CNT_ZERO;
      end
    end
  end

  // A pulse fires only on a 0->1 flip of stable. A release gives no pulse.
  always_comb begin
    pulse_nxt_s = {NPULSE{1'b0}};
    for (int ch = 0; ch < NPULSE; ch++) begin
      pulse_nxt_s[ch] = stable_nxt_s[ch] & ~stable_r[ch];
    end
  end

  // Debounce state and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_r <= {NCH{1'b0}};
      pulse_r  <= {NPULSE{1'b0}};
      for (int ch = 0; ch < NCH; ch++) begin
        cnt_r[ch] <= CNT_ZERO;
      end
    end else begin
      stable_r <= stable_nxt_s;
      pulse_r  <= pulse_nxt_s;
      for (int ch = 0; ch < NCH; ch++) begin
        cnt_r[ch] <= cnt_nxt_s[ch];
      end
    end
  end

  assign buttons   = pulse_r[2:0];
  assign equalizer = pulse_r[5:3];
  assign activator = stable_r[6];

endmodule
